ex_muldiv: RTL and testbench
============================

EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 The block SHALL have the port `clk`: input, 1 bit, the single rising-edge clock.
REQ-002 The block SHALL have the port `reset`: input, 1 bit, asynchronous active-high reset.
REQ-003 The block SHALL have the port `flush`: input, 1 bit, synchronous kill of any in-flight operation.
REQ-004 The block SHALL have the port `start_in`: input, 1 bit, request from EX stage that the current ID/EX contents are an RV32M operation.
REQ-005 The block SHALL have the port `funct3_in`: input, 3 bits, RV32M operation code: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-006 The block SHALL have the port `rdata1_in`: input, 32 bits, operand A (forwarded rs1 value).
REQ-007 The block SHALL have the port `rdata2_in`: input, 32 bits, operand B (forwarded rs2 value).
REQ-008 The block SHALL have the port `rd_in`: input, 5 bits, destination register of the operation.
REQ-009 The block SHALL have the port `stall_out`: output, 1 bit, hold request to PC, IF/ID and ID/EX registers.
REQ-010 The block SHALL have the port `busy_out`: output, 1 bit, high while the state is not IDLE.
REQ-011 The block SHALL have the port `done_out`: output, 1 bit, one-cycle pulse marking `result_out` valid.
REQ-012 The block SHALL have the port `result_out`: output, 32 bits, operation result.
REQ-013 The block SHALL have the port `rd_out`: output, 5 bits, destination register latched at start.

Function
REQ-014 The FSM SHALL have states IDLE, CALC and DONE, and SHALL be encoded in registers only.
REQ-015 In IDLE with `start_in`=1, the block SHALL latch operands, `funct3_in` and `rd_in` at the clock edge, clear the iteration counter and enter CALC.
REQ-016 In CALC, the block SHALL perform exactly one iteration per cycle (shift-add multiply or restoring divide) for 32 cycles, then enter DONE.
REQ-017 In DONE, the block SHALL assert `done_out`=1 for exactly one cycle with `result_out` and `rd_out` valid, then return to IDLE.
REQ-018 Latency SHALL be fixed at 33 cycles: a start edge at cycle N produces DONE during cycle N+33, independent of the operand values.
REQ-019 `stall_out` SHALL be combinational and equal (IDLE and `start_in`) or CALC; it SHALL be 0 in DONE so the pipeline advances, consuming the result in that cycle.
REQ-020 `start_in` asserted in CALC or DONE SHALL be ignored; there SHALL be no queuing.
REQ-021 Signed operands SHALL be converted to magnitudes before iteration, and the result sign SHALL be corrected in the final iteration, using a 64-bit product/remainder accumulator.
REQ-022 MUL SHALL return product[31:0]; MULH, MULHSU and MULHU SHALL return product[63:32] with signed×signed, signed×unsigned and unsigned×unsigned interpretation respectively.
REQ-023 Divide by zero SHALL produce DIV/DIVU = 0xFFFFFFFF and REM/REMU = operand A.
REQ-024 Signed overflow (0x80000000 / 0xFFFFFFFF) SHALL produce DIV = 0x80000000 and REM = 0.
REQ-025 Results for the special cases in REQ-023 and REQ-024 SHALL still appear after the full 33-cycle latency.
REQ-026 REM sign SHALL follow the dividend, and DIV SHALL truncate toward zero.
REQ-027 `flush`=1 at any clock edge SHALL force IDLE, suppress `done_out`, and override a simultaneous `start_in`.
REQ-028 `result_out` and `rd_out` SHALL hold their last DONE values until the next DONE.

Reset
REQ-029 Assertion of `reset` SHALL immediately force IDLE, and SHALL clear the counter, `done_out`, `busy_out`, `result_out` and `rd_out` to 0, independent of `clk`.
REQ-030 `stall_out` SHALL be 0 during reset regardless of `start_in`.
REQ-031 Reset asserted mid-CALC SHALL abandon the operation, and no `done_out` SHALL follow.

Verification
REQ-032 MUL: operands 7 and 6, `rd_in`=5, start at cycle 0 -> `stall_out` high cycles 0–32, `done_out` at cycle 33, `result_out`=42, `rd_out`=5.
REQ-033 MULH: 0xFFFFFFFF × 0xFFFFFFFF -> 0x00000000; the same operands with MULHU -> 0xFFFFFFFE; with MULHSU -> 0xFFFFFFFF.
REQ-034 DIV: -7 / 2 -> 0xFFFFFFFD; REM: -7 rem 2 -> 0xFFFFFFFF; DIVU: 100 / 0 -> 0xFFFFFFFF; REMU: 100 rem 0 -> 100.
REQ-035 DIV: 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0; latency SHALL be 33 cycles.
REQ-036 Flush at CALC cycle 10 -> IDLE next cycle, no `done_out`; a new start 2 cycles later completes normally.
REQ-037 Async reset pulse mid-CALC between clock edges -> all outputs 0 immediately, `busy_out`=0, no `done_out`; `start_in` during DONE is ignored (no second `done_out`).

Source files
------------

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV32M multiply/divide unit for the EX stage.
// Every operation takes a fixed 33 cycles after the start edge. There are
// 32 CALC iterations (shift-add multiply or restoring divide) on operand
// magnitudes, followed by one DONE cycle that presents the sign-corrected result.
//
// Ports:
//   clk        - rising-edge clock
//   reset      - asynchronous active-high reset
//   flush      - synchronous kill of any in-flight operation
//   start_in   - ID/EX holds an RV32M operation (accepted only in IDLE)
//   funct3_in  - 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
//   rdata1_in  - operand A (rs1)
//   rdata2_in  - operand B (rs2)
//   rd_in      - destination register
//   stall_out  - hold request to PC, IF/ID and ID/EX
//   busy_out   - state is not IDLE
//   done_out   - one-cycle pulse, result_out/rd_out valid
//   result_out - operation result, held until the next DONE
//   rd_out     - destination register of the result, held until the next DONE
module ex_muldiv (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        start_in,
    input  logic [2:0]  funct3_in,
    input  logic [31:0] rdata1_in,
    input  logic [31:0] rdata2_in,
    input  logic [4:0]  rd_in,
    output logic        stall_out,
    output logic        busy_out,
    output logic        done_out,
    output logic [31:0] result_out,
    output logic [4:0]  rd_out
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;        // product / {remainder, quotient} accumulator
    logic [31:0] opb_q, opb_d;        // |multiplicand| or |divisor|
    logic [2:0]  op_q, op_d;
    logic        neg_res_q, neg_res_d; // sign of product / quotient
    logic        neg_rem_q, neg_rem_d; // sign of remainder (follows dividend)
    logic [4:0]  rd_q, rd_d;
    logic [31:0] result_q, result_d;
    logic [4:0]  rd_out_q, rd_out_d;

    logic        accept, last_iter;
    logic        a_signed, b_signed, a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic [32:0] mul_sum, div_hi;
    logic [31:0] div_diff;
    logic        div_ge;
    logic [63:0] step_acc, prod;
    logic [31:0] quo, rem, final_res;

    // ---------------- operand conditioning ----------------
    always_comb begin
        a_signed = (funct3_in == 3'd1) || (funct3_in == 3'd2) ||
                   (funct3_in == 3'd4) || (funct3_in == 3'd6);
        b_signed = (funct3_in == 3'd1) || (funct3_in == 3'd4) ||
                   (funct3_in == 3'd6);
        a_neg    = a_signed && rdata1_in[31];
        b_neg    = b_signed && rdata2_in[31];
        a_mag    = a_neg ? (~rdata1_in + 32'd1) : rdata1_in;
        b_mag    = b_neg ? (~rdata2_in + 32'd1) : rdata2_in;
        accept   = (state_q == IDLE) && start_in && !flush;
        last_iter = (cnt_q == 5'd31);
    end

    // ---------------- one iteration ----------------
    always_comb begin
        // Shift-add: add multiplicand into the high half when the current
        // multiplier bit (LSB) is set, then shift the 65-bit sum right.
        mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
        // Restoring divide: shift left, trial-subtract the divisor from the
        // 33-bit partial remainder, shift the quotient bit into the LSB.
        div_hi   = acc_q[63:31];
        div_ge   = (div_hi >= {1'b0, opb_q});
        div_diff = div_hi[31:0] - opb_q;
        if (op_q[2]) begin
            step_acc = {(div_ge ? div_diff : div_hi[31:0]), acc_q[30:0], div_ge};
        end else begin
            step_acc = {mul_sum, acc_q[31:1]};
        end
    end

    // ---------------- sign correction of the final iteration ----------------
    always_comb begin
        prod = neg_res_q ? (~step_acc + 64'd1) : step_acc;
        quo  = step_acc[31:0];
        rem  = step_acc[63:32];
        case (op_q)
            3'd0:          final_res = prod[31:0];
            3'd1, 3'd2,
            3'd3:          final_res = prod[63:32];
            // A zero divisor yields an all-ones quotient from the restoring
            // loop; it must not be negated so DIV by 0 stays 0xFFFFFFFF.
            3'd4, 3'd5:    final_res = (neg_res_q && (opb_q != 32'd0)) ? (~quo + 32'd1) : quo;
            default:       final_res = neg_rem_q ? (~rem + 32'd1) : rem;
        endcase
    end

    // ---------------- datapath next state ----------------
    always_comb begin
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opb_d     = opb_q;
        op_d      = op_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        rd_d      = rd_q;
        result_d  = result_q;
        rd_out_d  = rd_out_q;
        if (accept) begin
            cnt_d     = '0;
            acc_d     = {32'd0, a_mag};
            opb_d     = b_mag;
            op_d      = funct3_in;
            neg_res_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            rd_d      = rd_in;
        end else if (state_q == CALC) begin
            acc_d = step_acc;
            cnt_d = cnt_q + 5'd1;
            if (last_iter && !flush) begin
                result_d = final_res;
                rd_out_d = rd_q;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            acc_q     <= '0;
            opb_q     <= '0;
            op_q      <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            rd_q      <= '0;
            result_q  <= '0;
            rd_out_q  <= '0;
        end else begin
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opb_q     <= opb_d;
            op_q      <= op_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            rd_q      <= rd_d;
            result_q  <= result_d;
            rd_out_q  <= rd_out_d;
        end
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start_in) state_d = CALC;
                CALC:    if (last_iter) state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy_out   = (state_q != IDLE);
        done_out   = (state_q == DONE);
        stall_out  = ((state_q == IDLE) && start_in && !reset) || (state_q == CALC);
        result_out = result_q;
        rd_out     = rd_out_q;
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: randomized and directed stimulus for ex_muldiv, checked every
// cycle against a transaction-level model. The model holds the expected
// result computed with plain 64-bit arithmetic and the start cycle of the
// operation in flight.
module tb_ex_muldiv;

    logic        clk = 1'b0;
    logic        reset, flush, start_in;
    logic [2:0]  funct3_in;
    logic [31:0] rdata1_in, rdata2_in;
    logic [4:0]  rd_in;
    logic        stall_out, busy_out, done_out;
    logic [31:0] result_out;
    logic [4:0]  rd_out;

    always #5 clk = ~clk;

    ex_muldiv dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .start_in   (start_in),
        .funct3_in  (funct3_in),
        .rdata1_in  (rdata1_in),
        .rdata2_in  (rdata2_in),
        .rd_in      (rd_in),
        .stall_out  (stall_out),
        .busy_out   (busy_out),
        .done_out   (done_out),
        .result_out (result_out),
        .rd_out     (rd_out)
    );

    int checks   = 0;
    int failures = 0;

    // ---------------- reference arithmetic ----------------
    function automatic logic [31:0] ref_model(input logic [2:0] f,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        logic signed [63:0] sa, sb, zb;
        logic [63:0] ua, ub, p;
        logic [31:0] r;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        zb = {32'd0, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        r  = '0;
        case (f)
            3'd0: begin p = ua * ub; r = p[31:0];  end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * zb; r = p[63:32]; end
            3'd3: begin p = ua * ub; r = p[63:32]; end
            3'd4: begin
                if (b == 32'd0) r = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
                else r = $signed(a) / $signed(b);
            end
            3'd5: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0) r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
                else r = $signed(a) % $signed(b);
            end
            default: r = (b == 32'd0) ? a : a % b;
        endcase
        return r;
    endfunction

    // ---------------- transaction model ----------------
    int          cyc = 0;
    int          m_start = 0;
    logic        m_active = 1'b0;
    logic [31:0] m_exp = '0, m_hold_res = '0;
    logic [4:0]  m_exp_rd = '0, m_hold_rd = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_active   <= 1'b0;
            m_hold_res <= '0;
            m_hold_rd  <= '0;
        end else begin
            if (m_active && (cyc - m_start == 33)) begin
                m_hold_res <= m_exp;
                m_hold_rd  <= m_exp_rd;
            end
            if (flush || (m_active && (cyc - m_start == 33))) begin
                m_active <= 1'b0;
            end else if (!m_active && start_in) begin
                m_active <= 1'b1;
                m_start  <= cyc;
                m_exp    <= ref_model(funct3_in, rdata1_in, rdata2_in);
                m_exp_rd <= rd_in;
            end
            cyc <= cyc + 1;
        end
    end

    // ---------------- comparison ----------------
    logic        chk_en = 1'b0;
    logic        pin_en = 1'b0;
    logic [31:0] pin_res = '0;
    logic [4:0]  pin_rd = '0;

    task chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks = checks + 1;
        if (act !== req) begin
            failures = failures + 1;
            $display("FAIL %s actual=%h required=%h cyc=%0d t=%0t", name, act, req, cyc, $time);
        end
    endtask

    always @(negedge clk or posedge reset) begin : compare
        int   ph;
        logic e_done, e_stall;
        #1;
        if (chk_en) begin
            if (reset) begin
                chk("rst_busy",   32'(busy_out),  32'd0);
                chk("rst_done",   32'(done_out),  32'd0);
                chk("rst_stall",  32'(stall_out), 32'd0);
                chk("rst_result", result_out,     32'd0);
                chk("rst_rd",     32'(rd_out),    32'd0);
            end else begin
                ph      = cyc - m_start;
                e_done  = m_active && (ph == 33);
                e_stall = m_active ? (ph != 33) : start_in;
                chk("busy",  32'(busy_out),  32'(m_active));
                chk("done",  32'(done_out),  32'(e_done));
                chk("stall", 32'(stall_out), 32'(e_stall));
                chk("result", result_out, e_done ? m_exp : m_hold_res);
                chk("rd", 32'(rd_out), 32'(e_done ? m_exp_rd : m_hold_rd));
                if (e_done && pin_en) begin
                    chk("lit_result", result_out, pin_res);
                    chk("lit_model",  m_exp,      pin_res);
                    chk("lit_rd",     32'(rd_out), 32'(pin_rd));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp, input bit poke);
        @(posedge clk); #2;
        pin_res = exp; pin_rd = rd; pin_en = 1'b1;
        start_in = 1'b1; funct3_in = f; rdata1_in = a; rdata2_in = b; rd_in = rd;
        @(posedge clk); #2;
        start_in = 1'b0; funct3_in = 3'($urandom); rdata1_in = $urandom;
        rdata2_in = $urandom; rd_in = 5'($urandom);
        repeat (32) @(posedge clk);
        #2;
        if (poke) start_in = 1'b1;   // request during DONE must be dropped
        @(posedge clk); #2;
        start_in = 1'b0;
        pin_en   = 1'b0;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            4:       return 32'd0 - 32'($urandom_range(1, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset = 1'b1; flush = 1'b0; start_in = 1'b1; funct3_in = '0;
        rdata1_in = '0; rdata2_in = '0; rd_in = '0;
        #8 chk_en = 1'b1;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0; start_in = 1'b0;

        run_op(3'd0, 32'd7,         32'd6,         5'd5,  32'd42,        1'b0);
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1,  32'h0000_0000, 1'b0);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE, 1'b0);
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFF, 1'b0);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2,         5'd4,  32'hFFFF_FFFD, 1'b0);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2,         5'd6,  32'hFFFF_FFFF, 1'b0);
        run_op(3'd5, 32'd100,       32'd0,         5'd7,  32'hFFFF_FFFF, 1'b0);
        run_op(3'd7, 32'd100,       32'd0,         5'd8,  32'd100,       1'b0);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9,  32'h8000_0000, 1'b0);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'd0,         1'b1);
        run_op(3'd4, 32'hFFFF_FF9C, 32'd0,         5'd11, 32'hFFFF_FFFF, 1'b0);
        run_op(3'd6, 32'hFFFF_FF9C, 32'd0,         5'd12, 32'hFFFF_FF9C, 1'b0);

        // flush at CALC cycle 10, then a new operation two cycles later
        @(posedge clk); #2;
        start_in = 1'b1; funct3_in = 3'd0; rdata1_in = 32'd3; rdata2_in = 32'd9; rd_in = 5'd20;
        @(posedge clk); #2 start_in = 1'b0;
        repeat (9) @(posedge clk);
        #2 flush = 1'b1;
        @(posedge clk); #2 flush = 1'b0;
        run_op(3'd0, 32'd12, 32'd12, 5'd21, 32'd144, 1'b0);

        // flush wins over a simultaneous start in IDLE
        @(posedge clk); #2;
        flush = 1'b1; start_in = 1'b1; funct3_in = 3'd5; rdata1_in = 32'd50; rdata2_in = 32'd7;
        @(posedge clk); #2 flush = 1'b0; start_in = 1'b0;

        // asynchronous reset pulse in the middle of CALC
        @(posedge clk); #2;
        start_in = 1'b1; funct3_in = 3'd5; rdata1_in = 32'd1000; rdata2_in = 32'd7; rd_in = 5'd30;
        @(posedge clk); #2 start_in = 1'b0;
        repeat (5) @(posedge clk);
        #2 reset = 1'b1; start_in = 1'b1;
        #5 reset = 1'b0; start_in = 1'b0;
        repeat (40) @(posedge clk);

        // randomized traffic, including starts during CALC/DONE and flushes
        for (int i = 0; i < 2500; i++) begin
            @(posedge clk); #2;
            start_in  = ($urandom_range(0, 3) == 0);
            flush     = ($urandom_range(0, 99) == 0);
            funct3_in = 3'($urandom_range(0, 7));
            rdata1_in = pick();
            rdata2_in = pick();
            rd_in     = 5'($urandom);
        end
        @(posedge clk); #2;
        start_in = 1'b0; flush = 1'b0;
        repeat (40) @(posedge clk);
        #3;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
